hpm_counters: RTL and testbench
===============================

# hpm_counters

Hardware performance-monitor counter bank feeding the CSR register file's `perf_*` port. It holds `MHPMCounterNum` 64-bit event counters (`mhpmcounter3..`) and their event selectors (`mhpmevent3..`), and increments each counter from per-cycle event strobes supplied by the pipeline. It serves combinational CSR reads and single-cycle CSR writes, and it raises a local counter-overflow interrupt request. It sits beside the CSR register file: its `perf_data_i`, `perf_addr_i` and `perf_we_i` inputs connect to that block's `perf_data_o`, `perf_addr_o` and `perf_we_o` outputs, and its `perf_data_o` output connects back to that block's `perf_data_i` input.

## Interface
- `XLEN`, default 64: counter and data width. Only 64 is supported.
- `MHPMCounterNum`, default 6: number of counters. Counter k (k = 3 .. 2+MHPMCounterNum) is the counter for CSR index k. Valid range is 1..29.
- `NumEvents`, default 16: width of the event-strobe vector. Valid range is 1..31.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `perf_addr_i` in 12: CSR address. Used for both read and write.
- `perf_data_i` in XLEN: CSR write data.
- `perf_we_i` in 1: CSR write strobe, one cycle.
- `perf_data_o` out XLEN: CSR read data for `perf_addr_i`. Combinational.
- `events_i` in NumEvents: event strobes. Bit e-1 is event id e, and means one occurrence this cycle.
- `mcountinhibit_i` in 32: bit k inhibits counter k.
- `stopcount_i` in 1: debug-mode stop-count. High freezes all counters.
- `lcof_irq_o` out 1: local counter-overflow interrupt request. Registered.

## Operation
Address map:
- `0xB00+k`: mhpmcounter k, full 64 bits, read/write.
- `0x320+k`: mhpmevent k, with two fields:
  - bits [4:0] SEL: the event id. 0 means no event.
  - bit 63 OF: the overflow flag.
  - All other bits are WARL and read 0.
- Any other address reads 0, and writes to it are ignored. This includes indices outside 3..2+MHPMCounterNum.

Counting, evaluated per counter each cycle:
- A counter increments by 1 when all of the following hold:
  - SEL is in 1..NumEvents;
  - `events_i[SEL-1]` is high;
  - `mcountinhibit_i[k]` is low;
  - `stopcount_i` is low.
- A SEL value greater than NumEvents never counts.

Overflow:
- When a counting increment wraps the counter from `2^64-1` to 0, OF is set in the same edge.
- OF is sticky. It is cleared only by a CSR write or by reset.

Simultaneous events:
- A CSR write to counter k in the same cycle as an increment of counter k: the write wins. The counter takes `perf_data_i` and the increment is dropped. OF is not set in that case.
- A CSR write to mhpmevent k in the same cycle as an overflow of counter k: the written OF value wins. The new SEL takes effect from the next cycle; the current cycle's increment uses the old SEL.

Interrupt and reads:
- `lcof_irq_o` is registered: the next value is the OR of all OF bits after this cycle's updates.
- `perf_data_o` is a pure function of `perf_addr_i` and the current register state. It has no dependency on `perf_we_i`.

## Timing
- Reset: all counters, SEL and OF fields clear to 0 asynchronously. `lcof_irq_o` goes to 0. `perf_data_o` then reads 0 for every address.
- Reads have zero latency: data is valid in the same cycle as the address.
- Writes are visible on `perf_data_o` in the cycle after `perf_we_i`.
- An event strobe in cycle N is visible in the counter value from cycle N+1.
- An overflow in cycle N sets OF, readable from cycle N+1. `lcof_irq_o` rises at the same edge, so it is high from cycle N+1.
- Clearing the last set OF bit by a write in cycle N drops `lcof_irq_o` from cycle N+1.
- Asserting reset mid-count clears state immediately, independent of the clock. Counting resumes on the first edge after reset is released.
- No back-pressure: every CSR access completes in one cycle.

## Test plan
- Reset: assert `rst_i` mid-simulation with no clock edge. Expect immediately: every mapped address reads 0 and `lcof_irq_o`=0.
- Basic count: write `0x323`=3, then pulse `events_i[2]` for 10 cycles. Expect `0xB03` reads 10. Pulsing `events_i[1]` leaves it at 10.
- Inhibit and stopcount: SEL=1 on counters 3 and 4, `mcountinhibit_i`=`0x8`, `events_i[0]` high for 5 cycles. Expect `0xB03`=0 and `0xB04`=5. Then raise `stopcount_i` for 4 cycles: expect both unchanged.
- Overflow: write `0xB05`=`0xFFFF_FFFF_FFFF_FFFE`, SEL=2, `events_i[1]` high for 3 cycles. Expect the counter to read 0 then 1, `0x325` reads `0x8000_0000_0000_0002`, and `lcof_irq_o`=1. Writing `0x325`=2 drops `lcof_irq_o` the next cycle.
- Write/increment collision: counter 3 counting every cycle, write `0xB03`=`0x100`. Expect a read of `0x100` the next cycle, then `0x101`.
- WARL and unmapped: write `0x323`=all-ones. Expect a read of `0x8000_0000_0000_001F`, which never counts when NumEvents=16. Writes to `0xB09` and `0x7C0` read back 0.

Source files
------------

// File: rtl/hpm_counters.sv
// hpm_counters: bank of 64-bit hardware performance-monitor counters
// (mhpmcounter3..) with event selectors and sticky overflow flags
// (mhpmevent3..). CSR reads are combinational. CSR writes take one cycle.
// A registered local counter-overflow interrupt request is also produced.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   perf_addr_i     CSR address (read and write)
//   perf_data_i     CSR write data
//   perf_we_i       CSR write strobe
//   perf_data_o     combinational CSR read data for perf_addr_i
//   events_i        per-cycle event strobes, bit e-1 = event id e
//   mcountinhibit_i bit k inhibits counter k
//   stopcount_i     debug stop-count, freezes all counters
//   lcof_irq_o      registered OR of all overflow flags
module hpm_counters #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned MHPMCounterNum = 6,
    parameter int unsigned NumEvents      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [11:0]          perf_addr_i,
    input  logic [XLEN-1:0]      perf_data_i,
    input  logic                 perf_we_i,
    output logic [XLEN-1:0]      perf_data_o,
    input  logic [NumEvents-1:0] events_i,
    input  logic [31:0]          mcountinhibit_i,
    input  logic                 stopcount_i,
    output logic                 lcof_irq_o
);

    localparam int unsigned NC      = MHPMCounterNum;
    localparam int unsigned SelW    = 5;
    localparam logic [11:0] CntBase = 12'hB00;
    localparam logic [11:0] EvtBase = 12'h320;

    logic [XLEN-1:0] cnt_q [NC];
    logic [XLEN-1:0] cnt_d [NC];
    logic [SelW-1:0] sel_q [NC];
    logic [SelW-1:0] sel_d [NC];
    logic [NC-1:0]   of_q;
    logic [NC-1:0]   of_d;
    logic [NC-1:0]   wr_cnt;
    logic [NC-1:0]   wr_evt;
    logic [NC-1:0]   inc;
    logic [31:0]     ev_vec;

    // Bit s of ev_vec is event id s; bit 0 (SEL=0) and ids above NumEvents are 0.
    assign ev_vec = 32'({events_i, 1'b0});

    // Per-counter write decode and increment qualification
    always_comb begin
        wr_cnt = '0;
        wr_evt = '0;
        inc    = '0;
        for (int i = 0; i < NC; i++) begin
            wr_cnt[i] = perf_we_i && (perf_addr_i == CntBase + 12'(i + 3));
            wr_evt[i] = perf_we_i && (perf_addr_i == EvtBase + 12'(i + 3));
            inc[i]    = ev_vec[sel_q[i]] && !mcountinhibit_i[5'(i + 3)] && !stopcount_i;
        end
    end

    // Next state: a CSR write beats the increment and any overflow it would cause
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
        end
        of_d = of_q;
        for (int i = 0; i < NC; i++) begin
            if (wr_cnt[i]) begin
                cnt_d[i] = perf_data_i;
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + XLEN'(1);
            end
            if (wr_evt[i]) begin
                sel_d[i] = perf_data_i[SelW-1:0];
                of_d[i]  = perf_data_i[XLEN-1];
            end else if (inc[i] && !wr_cnt[i] && (&cnt_q[i])) begin
                of_d[i]  = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NC; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            of_q       <= '0;
            lcof_irq_o <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            of_q       <= of_d;
            lcof_irq_o <= |of_d;
        end
    end

    // Combinational CSR read mux; unmapped addresses read 0
    always_comb begin
        perf_data_o = '0;
        for (int i = 0; i < NC; i++) begin
            if (perf_addr_i == CntBase + 12'(i + 3)) begin
                perf_data_o = cnt_q[i];
            end
            if (perf_addr_i == EvtBase + 12'(i + 3)) begin
                perf_data_o[XLEN-1]   = of_q[i];
                perf_data_o[SelW-1:0] = sel_q[i];
            end
        end
    end

endmodule

// File: tb/tb_hpm_counters.sv
// Directed, table-driven bench for hpm_counters (6 counters, 16 events).
`timescale 1ns/1ps
module tb_hpm_counters;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NC   = 6;
    localparam int unsigned NE   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [XLEN-1:0] rdata;
    logic [NE-1:0]   ev;
    logic [31:0]     inh;
    logic            stop;
    logic            irq;

    always #5 clk = ~clk;

    hpm_counters #(.XLEN(XLEN), .MHPMCounterNum(NC), .NumEvents(NE)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .perf_addr_i     (addr),
        .perf_data_i     (wdata),
        .perf_we_i       (we),
        .perf_data_o     (rdata),
        .events_i        (ev),
        .mcountinhibit_i (inh),
        .stopcount_i     (stop),
        .lcof_irq_o      (irq)
    );

    // One cycle of stimulus plus the read/irq values expected before the edge
    typedef struct {
        logic            we;
        logic [11:0]     addr;
        logic [XLEN-1:0] data;
        logic [NE-1:0]   ev;
        logic [31:0]     inh;
        logic            stop;
        logic            chk;
        logic [XLEN-1:0] exp_data;
        logic            exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] OFB  = 64'h8000_0000_0000_0000;

    function automatic vec_t mk(input logic w, input logic [11:0] a, input logic [63:0] d,
                                input logic [NE-1:0] e, input logic [31:0] ih, input logic s,
                                input logic c, input logic [63:0] x, input logic xi);
        vec_t v;
        v.we = w; v.addr = a; v.data = d; v.ev = e; v.inh = ih; v.stop = s;
        v.chk = c; v.exp_data = x; v.exp_irq = xi;
        return v;
    endfunction

    function automatic void add(input logic w, input logic [11:0] a, input logic [63:0] d,
                                input logic [NE-1:0] e, input logic [31:0] ih, input logic s,
                                input logic [63:0] x, input logic xi);
        vecs.push_back(mk(w, a, d, e, ih, s, 1'b1, x, xi));
    endfunction

    task automatic check(input string name, input logic [63:0] xd, input logic xi);
        tests++;
        if (rdata !== xd || irq !== xi) begin
            fails++;
            $display("FAIL %s: got data=%h irq=%b, expected data=%h irq=%b",
                     name, rdata, irq, xd, xi);
        end
    endtask

    // Drive one vector, compare before the next edge, then advance one cycle
    task automatic apply(input vec_t v, input string name);
        we = v.we; addr = v.addr; wdata = v.data; ev = v.ev; inh = v.inh; stop = v.stop;
        #1;
        if (v.chk) check(name, v.exp_data, v.exp_irq);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; ev = '0; inh = '0; stop = 1'b0;

        // Reset values and basic counting on event id 3
        add(0, 12'hB03, 0, 0, 0, 0, 0, 0);
        add(0, 12'h323, 0, 0, 0, 0, 0, 0);
        add(0, 12'hB08, 0, 0, 0, 0, 0, 0);
        add(1, 12'h323, 3, 0, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) add(0, 12'hB03, 0, 16'h0004, 0, 0, 64'(j), 0);
        add(0, 12'hB03, 0, 16'h0002, 0, 0, 10, 0);
        add(0, 12'hB03, 0, 16'h0002, 0, 0, 10, 0);
        add(0, 12'h323, 0, 0, 0, 0, 3, 0);
        // Inhibit and stopcount
        add(1, 12'h323, 1, 0, 0, 0, 3, 0);
        add(1, 12'h324, 1, 0, 0, 0, 0, 0);
        add(1, 12'hB03, 0, 0, 0, 0, 10, 0);
        add(0, 12'hB03, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) add(0, 12'hB04, 0, 16'h0001, 32'h8, 0, 64'(j), 0);
        add(0, 12'hB03, 0, 0, 32'h8, 0, 0, 0);
        add(0, 12'hB04, 0, 0, 32'h8, 0, 5, 0);
        for (int j = 0; j < 4; j++)
            add(0, (j % 2 == 0) ? 12'hB03 : 12'hB04, 0, 16'h0001, 0, 1,
                (j % 2 == 0) ? 64'd0 : 64'd5, 0);
        add(0, 12'hB03, 0, 0, 0, 0, 0, 0);
        add(0, 12'hB04, 0, 0, 0, 0, 5, 0);
        // Overflow of counter 5 and clearing OF
        add(1, 12'hB05, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0);
        add(1, 12'h325, 2, 0, 0, 0, 0, 0);
        add(0, 12'hB05, 0, 16'h0002, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        add(0, 12'hB05, 0, 16'h0002, 0, 0, ONES, 0);
        add(0, 12'hB05, 0, 16'h0002, 0, 0, 0, 1);
        add(0, 12'hB05, 0, 0, 0, 0, 1, 1);
        add(0, 12'h325, 0, 0, 0, 0, OFB | 64'd2, 1);
        add(1, 12'h325, 2, 0, 0, 0, OFB | 64'd2, 1);
        add(0, 12'h325, 0, 0, 0, 0, 2, 0);
        // Counter write collides with increment
        add(0, 12'hB03, 0, 16'h0001, 0, 0, 0, 0);
        add(1, 12'hB03, 64'h100, 16'h0001, 0, 0, 1, 0);
        add(0, 12'hB03, 0, 16'h0001, 0, 0, 64'h100, 0);
        add(0, 12'hB03, 0, 16'h0001, 0, 0, 64'h101, 0);
        add(0, 12'hB03, 0, 0, 0, 0, 64'h102, 0);
        // WARL event register: SEL=31 never counts, written OF drives irq
        add(1, 12'h323, ONES, 0, 0, 0, 1, 0);
        add(0, 12'h323, 0, 0, 0, 0, OFB | 64'h1F, 1);
        for (int j = 0; j < 3; j++) add(0, 12'hB03, 0, 16'hFFFF, 0, 0, 64'h102, 1);
        add(1, 12'h323, 0, 0, 0, 0, OFB | 64'h1F, 1);
        add(0, 12'h323, 0, 0, 0, 0, 0, 0);
        // Unmapped addresses
        add(1, 12'hB09, 64'h1234, 0, 0, 0, 0, 0);
        add(0, 12'hB09, 0, 0, 0, 0, 0, 0);
        add(1, 12'h7C0, 64'h5555, 0, 0, 0, 0, 0);
        add(0, 12'h7C0, 0, 0, 0, 0, 0, 0);
        add(1, 12'h322, 64'hFF, 0, 0, 0, 0, 0);
        add(0, 12'h322, 0, 0, 0, 0, 0, 0);
        add(0, 12'hB02, 0, 0, 0, 0, 0, 0);
        // Event write in the wrap cycle: written OF wins, old SEL counts this cycle
        add(1, 12'hB06, ONES, 0, 0, 0, 0, 0);
        add(1, 12'h326, 1, 0, 0, 0, 0, 0);
        add(1, 12'h326, 5, 16'h0001, 0, 0, 1, 0);
        add(0, 12'h326, 0, 0, 0, 0, 5, 0);
        add(0, 12'hB06, 0, 16'h0010, 0, 0, 0, 0);
        add(0, 12'hB06, 0, 0, 0, 0, 1, 0);
        // Counter write in the wrap cycle: no OF
        add(1, 12'hB07, ONES, 0, 0, 0, 0, 0);
        add(1, 12'h327, 1, 0, 0, 0, 0, 0);
        add(1, 12'hB07, 7, 16'h0001, 0, 0, ONES, 0);
        add(0, 12'h327, 0, 0, 0, 0, 1, 0);
        add(0, 12'hB07, 0, 0, 0, 0, 7, 0);

        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < vecs.size(); n++) apply(vecs[n], $sformatf("vec%0d", n));

        // Asynchronous reset mid-count, no clock edge involved
        apply(mk(1, 12'hB04, 64'h55, 16'h0001, 0, 0, 0, 0, 0), "pre_rst_w0");
        apply(mk(1, 12'h324, OFB | 64'd1, 0, 0, 0, 0, 0, 0), "pre_rst_w1");
        apply(mk(0, 12'h324, 0, 0, 0, 0, 1, OFB | 64'd1, 1), "pre_rst_of");
        rst = 1'b1;
        #0.2;
        check("rst_irq", 64'd0, 1'b0);
        for (int k = 3; k < 3 + NC; k++) begin
            addr = 12'hB00 + 12'(k);
            #0.2;
            check($sformatf("rst_cnt%0d", k), 64'd0, 1'b0);
            addr = 12'h320 + 12'(k);
            #0.2;
            check($sformatf("rst_evt%0d", k), 64'd0, 1'b0);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(1, 12'h323, 1, 16'h0001, 0, 0, 1, 0, 0), "post_rst_w");
        apply(mk(0, 12'hB03, 0, 16'h0001, 0, 0, 1, 0, 0), "post_rst_c0");
        apply(mk(0, 12'hB03, 0, 0, 0, 0, 1, 1, 0), "post_rst_c1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
